// File: rtl/bg_pixel_fifo_if.sv
// Push/pixel bus between the background fetcher, the pixel FIFO and the pixel mixer.
// master: fetcher/mixer side that drives control and rows; slave: the FIFO itself.
interface bg_pixel_fifo_if #(
  parameter int X_MAX = 160
);
  localparam int XW = $clog2(X_MAX);

  logic                 tclk_in;
  logic                 line_start_in;
  logic [7:0]           SCX_in;
  logic                 shift_ena_in;
  logic                 valid_pixels_in;
  logic [7:0][1:0]      pixels_in;       // pixels_in[0] is the leftmost pixel
  logic                 bg_fifo_empty_out;
  logic [1:0]           pixel_out;
  logic                 pixel_valid_out;
  logic [XW-1:0]        X_out;
  logic                 line_done_out;
  logic                 overflow_out;

  modport master (
    output tclk_in, line_start_in, SCX_in, shift_ena_in, valid_pixels_in, pixels_in,
    input  bg_fifo_empty_out, pixel_out, pixel_valid_out, X_out, line_done_out, overflow_out
  );

  modport slave (
    input  tclk_in, line_start_in, SCX_in, shift_ena_in, valid_pixels_in, pixels_in,
    output bg_fifo_empty_out, pixel_out, pixel_valid_out, X_out, line_done_out, overflow_out
  );
endinterface

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO and shifter. Accepts 8-pixel rows on a rising edge of
// valid_pixels_in, shifts one colour index per T-cycle, tracks screen X and
// stops after X_MAX pixels per scanline.
// Optional feature: define BG_FINE_SCROLL_EN to drop the first SCX[2:0] pixels
// of every line (fine scroll); without it every pop emits and SCX_in is ignored.
module bg_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int X_MAX = 160
) (
  input logic           clk_in,
  input logic           rst_in,
  bg_pixel_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = $clog2(X_MAX);

  // IDLE doubles as line_done: pops and pushes are blocked until the next line
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_reg;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg;
  logic [XW-1:0]   x_reg, x_out_reg;
  logic [1:0]      pixel_reg;
  logic            pvalid_reg, empty_reg, ovf_reg, vprev_reg;
  logic [2:0]      discard;
  logic [AW-1:0]   wr_addr [8];
  logic            line_start, push_edge, push_ok, push_drop, pop, emit, done;

`ifdef BG_FINE_SCROLL_EN
  logic [2:0]      discard_reg;
  logic            unused_scx;
  assign discard    = discard_reg;
  assign unused_scx = ^bus.SCX_in[7:3];
`else
  logic            unused_scx;
  assign discard    = 3'd0;
  assign unused_scx = ^bus.SCX_in;
`endif

  assign done       = (state_reg == IDLE);
  assign line_start = bus.tclk_in & bus.line_start_in;
  // a push is the rising edge of the fetcher's level-held valid
  assign push_edge  = bus.tclk_in & ~line_start & bus.valid_pixels_in & ~vprev_reg;
  assign push_ok    = push_edge & (count_reg <= CW'(DEPTH - 8)) & ~done;
  assign push_drop  = push_edge & ~push_ok & ~done;
  // pop uses the pre-update count, so a row pushed this cycle is not yet poppable
  assign pop        = bus.tclk_in & ~line_start & bus.shift_ena_in & (count_reg != CW'(0)) & ~done;
  assign emit       = pop & (discard == 3'd0);

  // one write address per lane of the incoming row, wrapping at DEPTH
  for (genvar gi = 0; gi < 8; gi++) begin : g_wr_addr
    assign wr_addr[gi] = tail_reg + AW'(gi);
  end

  // pixel storage: write a whole row at the tail when a push is accepted
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      for (int i = 0; i < 8; i++) begin
        mem[wr_addr[i]] <= bus.pixels_in[i];
      end
    end
  end

  // pointers, count, scanline state and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg  <= IDLE;
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      x_reg      <= '0;
      x_out_reg  <= '0;
      pixel_reg  <= '0;
      pvalid_reg <= 1'b0;
      empty_reg  <= 1'b1;
      ovf_reg    <= 1'b0;
      vprev_reg  <= 1'b0;
`ifdef BG_FINE_SCROLL_EN
      discard_reg <= 3'd0;
`endif
    end else begin
      pvalid_reg <= 1'b0;
      empty_reg  <= (count_reg == CW'(0));
      if (line_start) begin
        state_reg <= ACTIVE;
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        x_reg     <= '0;
        ovf_reg   <= 1'b0;
        vprev_reg <= 1'b0;
`ifdef BG_FINE_SCROLL_EN
        discard_reg <= bus.SCX_in[2:0];
`endif
      end else if (bus.tclk_in) begin
        vprev_reg <= bus.valid_pixels_in;
        count_reg <= count_reg + (push_ok ? CW'(8) : CW'(0)) - CW'(pop);
        if (push_ok) begin
          tail_reg <= tail_reg + AW'(8);
        end
        if (push_drop) begin
          ovf_reg <= 1'b1;
        end
        if (pop) begin
          head_reg <= head_reg + AW'(1);
        end
        if (emit) begin
          pixel_reg  <= mem[head_reg];
          x_out_reg  <= x_reg;
          x_reg      <= x_reg + XW'(1);
          pvalid_reg <= 1'b1;
          if (x_reg == XW'(X_MAX - 1)) begin
            state_reg <= IDLE;
          end
        end
`ifdef BG_FINE_SCROLL_EN
        if (pop && !emit) begin
          discard_reg <= discard_reg - 3'd1;
        end
`endif
      end
    end
  end

  assign bus.bg_fifo_empty_out = empty_reg;
  assign bus.pixel_out         = pixel_reg;
  assign bus.pixel_valid_out   = pvalid_reg;
  assign bus.X_out             = x_out_reg;
  assign bus.line_done_out     = done;
  assign bus.overflow_out      = ovf_reg;
endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Testbench for bg_pixel_fifo: a queue-based model of the line/FIFO behaviour
// checked every clk, plus directed scenarios with hand-computed expectations.
// Honours BG_FINE_SCROLL_EN the same way as the design.
module tb_bg_pixel_fifo;
  localparam int X_MAX = 160;
  localparam int DEPTH = 16;
`ifdef BG_FINE_SCROLL_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bg_pixel_fifo_if #(.X_MAX(X_MAX)) bus();
  bg_pixel_fifo #(.DEPTH(DEPTH), .X_MAX(X_MAX)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  // behavioural model state
  int mq[$];
  int m_disc = 0, m_x = 0;
  bit m_done = 1'b1, m_ovf = 1'b0, m_vprev = 1'b0;
  bit s_emit, s_rst;
  int s_pix, s_x;
  // expected DUT outputs
  bit e_pvalid = 1'b0, e_done = 1'b1, e_ovf = 1'b0, e_empty = 1'b1;
  int e_pix = 0, e_x = 0;
  // observed emissions
  int seen_pix[$];
  int seen_x[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // model step for one T-cycle, using the inputs currently driven
  task automatic model_step();
    int pre;
    bit done_pre, do_pop, edge_seen;
    s_emit = 1'b0;
    s_rst  = 1'b0;
    if (!rst) begin
      mq.delete(); m_disc = 0; m_x = 0; m_done = 1'b1; m_ovf = 1'b0; m_vprev = 1'b0;
      s_rst = 1'b1;
      return;
    end
    if (bus.line_start_in) begin
      mq.delete(); m_x = 0; m_done = 1'b0; m_ovf = 1'b0; m_vprev = 1'b0;
      m_disc = FS ? int'(bus.SCX_in % 8) : 0;
      return;
    end
    pre = mq.size();
    done_pre = m_done;
    do_pop = bus.shift_ena_in && pre > 0 && !done_pre;
    edge_seen = bus.valid_pixels_in && !m_vprev;
    m_vprev = bus.valid_pixels_in;
    if (do_pop) begin
      int p;
      p = mq.pop_front();
      if (m_disc > 0) m_disc--;
      else begin
        s_emit = 1'b1; s_pix = p; s_x = m_x; m_x++;
        if (m_x == X_MAX) m_done = 1'b1;
      end
    end
    if (edge_seen && !done_pre) begin
      if (pre <= DEPTH - 8) begin
        for (int k = 0; k < 8; k++) mq.push_back(int'(bus.pixels_in[k]));
      end else m_ovf = 1'b1;
    end
  endtask

  // one T-cycle: tclk high for one clk, low for the next; called after a negedge
  task automatic tick();
    bus.tclk_in = 1'b1;
    model_step();
    @(posedge clk); #1;
    e_pvalid = s_emit;
    if (s_emit) begin e_pix = s_pix; e_x = s_x; end
    if (s_rst) begin e_pix = 0; e_x = 0; e_empty = 1'b1; end
    e_done = m_done;
    e_ovf  = m_ovf;
    @(negedge clk);
    bus.tclk_in = 1'b0;
    @(posedge clk); #1;
    e_pvalid = 1'b0;
    e_empty  = (mq.size() == 0);
    @(negedge clk);
  endtask

  task automatic set_row(input int r[8]);
    for (int k = 0; k < 8; k++) bus.pixels_in[k] = 2'(r[k]);
  endtask

  task automatic line_start(input logic [7:0] scx);
    bus.line_start_in = 1'b1;
    bus.SCX_in = scx;
    tick();
    bus.line_start_in = 1'b0;
  endtask

  // single compare process: all outputs against the model on every clk
  always @(negedge clk) begin
    chk("pixel_valid_out", bus.pixel_valid_out, e_pvalid);
    chk("pixel_out", bus.pixel_out, e_pix);
    chk("X_out", bus.X_out, e_x);
    chk("line_done_out", bus.line_done_out, e_done);
    chk("overflow_out", bus.overflow_out, e_ovf);
    chk("bg_fifo_empty_out", bus.bg_fifo_empty_out, e_empty);
    if (bus.pixel_valid_out === 1'b1) begin
      seen_pix.push_back(int'(bus.pixel_out));
      seen_x.push_back(int'(bus.X_out));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int row0[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rowh[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
    int rowa[8]  = '{3, 2, 1, 0, 3, 2, 1, 0};
    int rowb[8]  = '{1, 1, 2, 2, 3, 3, 0, 0};
    int rowc[8]  = '{2, 2, 2, 2, 2, 2, 2, 2};
    int rows[8]  = '{2, 0, 3, 1, 1, 3, 0, 2};
    int exp9[9]  = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp5[5]  = '{1, 1, 3, 0, 2};
    int ticks, bad;

    bus.tclk_in = 1'b0; bus.line_start_in = 1'b0; bus.SCX_in = 8'd0;
    bus.shift_ena_in = 1'b0; bus.valid_pixels_in = 1'b0;
    set_row(row0);

    // reset state
    rst = 1'b0;
    tick(); tick();
    chk("lit_rst_valid", bus.pixel_valid_out, 1'b0);
    chk("lit_rst_done", bus.line_done_out, 1'b1);
    chk("lit_rst_empty", bus.bg_fifo_empty_out, 1'b1);
    chk("lit_rst_x", bus.X_out, 0);
    chk("lit_rst_ovf", bus.overflow_out, 1'b0);
    rst = 1'b1;

    // single row into an empty FIFO, popped in order
    line_start(8'd0);
    seen_pix.delete(); seen_x.delete();
    bus.shift_ena_in = 1'b1;
    set_row(row0); bus.valid_pixels_in = 1'b1;
    tick();
    bus.valid_pixels_in = 1'b0;
    repeat (8) tick();
    chk("lit_row_count", seen_pix.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < seen_pix.size()) chk($sformatf("lit_row_pix%0d", i), seen_pix[i], row0[i]);
    chk("lit_row_first_x", seen_x.size() > 0 ? seen_x[0] : -1, 0);
    chk("lit_row_empty", bus.bg_fifo_empty_out, 1'b1);

    // valid held for 3 T-cycles: only one row accepted
    bus.shift_ena_in = 1'b0;
    set_row(rowh); bus.valid_pixels_in = 1'b1;
    repeat (3) tick();
    bus.valid_pixels_in = 1'b0;
    seen_pix.delete(); seen_x.delete();
    bus.shift_ena_in = 1'b1;
    repeat (12) tick();
    chk("lit_held_count", seen_pix.size(), 8);

    // overflow with count=9
    bus.shift_ena_in = 1'b0;
    set_row(rowa); bus.valid_pixels_in = 1'b1; tick();
    bus.valid_pixels_in = 1'b0; tick();
    set_row(rowb); bus.valid_pixels_in = 1'b1; tick();
    bus.valid_pixels_in = 1'b0;
    bus.shift_ena_in = 1'b1;
    repeat (7) tick();
    bus.shift_ena_in = 1'b0;
    chk("lit_ovf_before", bus.overflow_out, 1'b0);
    set_row(rowc); bus.valid_pixels_in = 1'b1; tick();
    chk("lit_ovf_set", bus.overflow_out, 1'b1);
    bus.valid_pixels_in = 1'b0;
    seen_pix.delete(); seen_x.delete();
    bus.shift_ena_in = 1'b1;
    repeat (12) tick();
    chk("lit_ovf_count", seen_pix.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < seen_pix.size()) chk($sformatf("lit_ovf_pix%0d", i), seen_pix[i], exp9[i]);
    line_start(8'd0);
    chk("lit_ovf_cleared", bus.overflow_out, 1'b0);

    // fine scroll: SCX low bits 5, upper bits must be ignored
    line_start(8'hFD);
    set_row(row0); bus.valid_pixels_in = 1'b1; tick();
    bus.valid_pixels_in = 1'b0;
    seen_pix.delete(); seen_x.delete();
    repeat (8) tick();
    chk("lit_scx_count", seen_pix.size(), FS ? 3 : 8);
    chk("lit_scx_first_pix", seen_pix.size() > 0 ? seen_pix[0] : -1, FS ? 1 : 0);
    chk("lit_scx_first_x", seen_x.size() > 0 ? seen_x[0] : -1, 0);

    // shifter stall for 6 T-cycles mid-line
    line_start(8'd0);
    set_row(rows); bus.valid_pixels_in = 1'b1; tick();
    bus.valid_pixels_in = 1'b0;
    repeat (3) tick();
    seen_pix.delete(); seen_x.delete();
    bus.shift_ena_in = 1'b0;
    repeat (6) tick();
    chk("lit_stall_none", seen_pix.size(), 0);
    chk("lit_stall_x", bus.X_out, 2);
    bus.shift_ena_in = 1'b1;
    repeat (6) tick();
    chk("lit_stall_resume", seen_pix.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seen_pix.size()) chk($sformatf("lit_stall_pix%0d", i), seen_pix[i], exp5[i]);
    chk("lit_stall_x3", seen_x.size() > 0 ? seen_x[0] : -1, 3);

    // full scanline with rows pushed on demand
    line_start(8'd0);
    seen_pix.delete(); seen_x.delete();
    ticks = 0;
    while (bus.line_done_out !== 1'b1 && ticks < 2000) begin
      bus.valid_pixels_in = bus.bg_fifo_empty_out && !bus.valid_pixels_in;
      for (int k = 0; k < 8; k++) bus.pixels_in[k] = 2'((ticks + k) % 4);
      tick();
      ticks++;
    end
    chk("lit_line_timeout", ticks < 2000, 1'b1);
    bus.valid_pixels_in = 1'b0;
    chk("lit_line_count", seen_x.size(), X_MAX);
    bad = 0;
    foreach (seen_x[i]) if (seen_x[i] != i) bad++;
    chk("lit_line_x_order", bad, 0);
    chk("lit_line_last_x", bus.X_out, X_MAX - 1);
    chk("lit_line_done", bus.line_done_out, 1'b1);
    // pushes and pops are blocked after the line completes
    set_row(row0); bus.valid_pixels_in = 1'b1; tick();
    bus.valid_pixels_in = 1'b0;
    repeat (4) tick();
    chk("lit_line_no_more", seen_x.size(), X_MAX);
    chk("lit_line_no_ovf", bus.overflow_out, 1'b0);

    // reset mid-line: immediate, no pixel pulse afterwards
    line_start(8'd0);
    set_row(rowb); bus.valid_pixels_in = 1'b1; tick();
    bus.valid_pixels_in = 1'b0;
    repeat (2) tick();
    seen_pix.delete(); seen_x.delete();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("lit_mrst_no_pulse", seen_pix.size(), 0);
    chk("lit_mrst_done", bus.line_done_out, 1'b1);
    chk("lit_mrst_empty", bus.bg_fifo_empty_out, 1'b1);
    chk("lit_mrst_x", bus.X_out, 0);
    chk("lit_mrst_pix", bus.pixel_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
